// File: rtl/fcc_pkg.sv
// Shared constants and state encoding for the connected-components relabel stage.
package fcc_pkg;

  localparam int FCC_BG_LABEL = 0;
  localparam int FCC_BG_CID   = 0;
  localparam int FCC_LABEL_W  = 16;
  localparam int FCC_CID_W    = 10;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_QUERY = 3'd2,
    S_WAIT  = 3'd3,
    S_MAP   = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } relabel_state_e;

endpackage

// File: rtl/fcc_relabel_map.sv
// Root-to-cluster-ID map: per-entry valid bit plus ID, with a one-entry-per-cycle clear port.
module fcc_relabel_map
  import fcc_pkg::*;
#(
  parameter int CID_W     = FCC_CID_W,
  parameter int MAP_DEPTH = 1 << FCC_LABEL_W,
  parameter int ADDR_W    = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [CID_W-1:0]  rd_id,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CID_W-1:0]  wr_id
);

  logic             map_valid [MAP_DEPTH];
  logic [CID_W-1:0] map_id    [MAP_DEPTH];

  // Clear and allocation never overlap: the sweep owns the map while it runs.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      map_valid[clr_addr] <= 1'b0;
    end else if (wr_en) begin
      map_valid[wr_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      map_id[wr_addr] <= wr_id;
    end
  end

  assign rd_valid = map_valid[rd_addr];
  assign rd_id    = map_id[rd_addr];

endmodule

// File: rtl/fcc_relabel.sv
// Second-pass relabeler: queries union-find roots and maps them to dense cluster IDs.
// Optional macro FCC_RELABEL_CACHE_EN adds a one-entry label->root cache.
module fcc_relabel
  import fcc_pkg::*;
#(
  parameter int LABEL_W   = FCC_LABEL_W,
  parameter int CID_W     = FCC_CID_W,
  parameter int MAP_DEPTH = 1 << LABEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [LABEL_W-1:0] s_label,
  input  logic               s_last,
  output logic               q_valid,
  input  logic               q_ready,
  output logic [LABEL_W-1:0] q_label,
  input  logic               q_out_valid,
  input  logic [LABEL_W-1:0] q_root,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CID_W-1:0]   m_cluster,
  output logic               m_last,
  output logic               frame_done,
  output logic [CID_W-1:0]   num_clusters,
  output logic               overflow
);

  localparam int ADDR_W = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1;

  relabel_state_e    state, state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_last;
  logic [CID_W-1:0]  next_id;
  logic [LABEL_W-1:0] root_r;
  logic              s_bg;
  logic              cache_hit;
  logic              rd_valid;
  logic [CID_W-1:0]  rd_id;
  logic              wr_en;

  assign clr_last = (clr_addr == ADDR_W'(MAP_DEPTH - 1));
  assign s_bg     = (s_label == LABEL_W'(FCC_BG_LABEL));

`ifdef FCC_RELABEL_CACHE_EN
  logic [LABEL_W-1:0] last_label;
  logic [LABEL_W-1:0] last_root;
  logic               last_hit_valid;

  assign cache_hit = last_hit_valid && (s_label == last_label) && !s_bg;
`else
  assign cache_hit = 1'b0;
`endif

  assign s_ready    = (state == S_IDLE);
  assign q_valid    = (state == S_QUERY);
  assign m_valid    = (state == S_OUT);
  assign frame_done = (state == S_DONE);
  assign wr_en      = (state == S_MAP) && !rd_valid && (next_id != '0);

  fcc_relabel_map #(
    .CID_W     (CID_W),
    .MAP_DEPTH (MAP_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_map (
    .clk      (clk),
    .clr_en   (state == S_CLEAR),
    .clr_addr (clr_addr),
    .rd_addr  (root_r[ADDR_W-1:0]),
    .rd_valid (rd_valid),
    .rd_id    (rd_id),
    .wr_en    (wr_en),
    .wr_addr  (root_r[ADDR_W-1:0]),
    .wr_id    (next_id)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CLEAR;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_CLEAR: if (clr_last) state_nx = S_IDLE;
      S_IDLE: begin
        if (s_valid) begin
          if (s_bg)           state_nx = S_OUT;
          else if (cache_hit) state_nx = S_MAP;
          else                state_nx = S_QUERY;
        end
      end
      S_QUERY: if (q_ready) state_nx = S_WAIT;
      S_WAIT:  if (q_out_valid) state_nx = S_MAP;
      S_MAP:   state_nx = S_OUT;
      S_OUT:   if (m_ready) state_nx = m_last ? S_DONE : S_IDLE;
      S_DONE:  state_nx = S_CLEAR;
      default: state_nx = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_addr     <= '0;
      next_id      <= CID_W'(1);
      overflow     <= 1'b0;
      q_label      <= '0;
      m_cluster    <= '0;
      m_last       <= 1'b0;
      num_clusters <= '0;
`ifdef FCC_RELABEL_CACHE_EN
      last_hit_valid <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_CLEAR: begin
          if (clr_last) begin
            clr_addr <= '0;
            next_id  <= CID_W'(1);
            overflow <= 1'b0;
          end else begin
            clr_addr <= clr_addr + ADDR_W'(1);
          end
`ifdef FCC_RELABEL_CACHE_EN
          last_hit_valid <= 1'b0;
`endif
        end
        S_IDLE: begin
          if (s_valid) begin
            m_last <= s_last;
            if (s_bg) m_cluster <= CID_W'(FCC_BG_CID);
            else      q_label   <= s_label;
          end
        end
`ifdef FCC_RELABEL_CACHE_EN
        S_WAIT: if (q_out_valid) last_hit_valid <= 1'b1;
`endif
        S_MAP: begin
          // A wrapped next_id means every ID is taken: new roots fall back to background.
          if (rd_valid) begin
            m_cluster <= rd_id;
          end else if (next_id != '0) begin
            m_cluster <= next_id;
            next_id   <= next_id + CID_W'(1);
          end else begin
            m_cluster <= CID_W'(FCC_BG_CID);
            overflow  <= 1'b1;
          end
        end
        S_DONE: num_clusters <= overflow ? {CID_W{1'b1}} : next_id - CID_W'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_WAIT && q_out_valid) begin
      root_r <= q_root;
`ifdef FCC_RELABEL_CACHE_EN
      last_label <= q_label;
      last_root  <= q_root;
`endif
    end
`ifdef FCC_RELABEL_CACHE_EN
    else if (state == S_IDLE && s_valid && cache_hit) begin
      root_r <= last_root;
    end
`endif
  end

endmodule
